// File: rtl/fir_pkg.sv
// Shared constants and types for the FIR sample feeder.
package fir_pkg;

    localparam int FIR_WIDTH   = 18;
    localparam int FIR_TAPS    = 128;
    localparam int FIR_PHASE_W = $clog2(FIR_TAPS);

    typedef enum logic {
        WAIT = 1'b0,
        RUN  = 1'b1
    } feeder_state_t;

endpackage

// File: rtl/fir_sample_fifo.sv
// Small synchronous FIFO with registered full/empty flags and a combinational head read.
module fir_sample_fifo
    import fir_pkg::*;
#(
    parameter int WIDTH = FIR_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic [AW:0]      count_next;
    logic             push_en;
    logic             pop_en;

    // A push while full is dropped even if a pop frees a slot in the same cycle.
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;

    always_comb begin
        count_next = count_reg + (AW+1)'(push_en) - (AW+1)'(pop_en);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            full       <= 1'b0;
            empty      <= 1'b1;
        end else begin
            if (push_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_en)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_next;
            full      <= (count_next == (AW+1)'(DEPTH));
            empty     <= (count_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) mem[wr_ptr_reg] <= wdata;
    end

    assign rdata = mem[rd_ptr_reg];

endmodule

// File: rtl/fir_sample_feeder.sv
// Paces a valid/ready sample stream into the serial FIR filter and re-emits its results.
// Optional FIR_FEEDER_STALL_CNT_EN adds a saturating count of idle cycles with an empty buffer.
module fir_sample_feeder
    import fir_pkg::*;
#(
    parameter int WIDTH      = FIR_WIDTH,
    parameter int TAPS       = FIR_TAPS,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] fir_sig,
    output logic             fir_ready,
    input  logic [WIDTH-1:0] fir_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef FIR_FEEDER_STALL_CNT_EN
    ,
    output logic [15:0]      stall_cnt
`endif
);

    localparam int                 PHASE_W = $clog2(TAPS);
    localparam logic [PHASE_W-1:0] LAST    = PHASE_W'(TAPS - 1);

    feeder_state_t      state_reg;
    feeder_state_t      state_next;
    logic [PHASE_W-1:0] phase_reg;
    logic               primed_reg;
    logic               fifo_full;
    logic               fifo_empty;
    logic [WIDTH-1:0]   fifo_head;
    logic               start;
    logic               pop;
    logic               capture;

    fir_sample_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (in_valid),
        .pop   (pop),
        .wdata (in_data),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign in_ready = !fifo_full;
    assign start    = !fifo_empty && (!out_valid || out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= WAIT;
            phase_reg <= '0;
        end else begin
            state_reg <= state_next;
            phase_reg <= (state_reg == RUN) ? phase_reg + 1'b1 : '0;
        end
    end

    always_comb begin
        state_next = state_reg;
        pop        = 1'b0;
        case (state_reg)
            WAIT: begin
                if (start) begin
                    state_next = RUN;
                    pop        = 1'b1;
                end
            end
            RUN: begin
                if (phase_reg == LAST) begin
                    if (start) pop = 1'b1;
                    else       state_next = WAIT;
                end
            end
            default: state_next = WAIT;
        endcase
    end

    // The filter result is valid by phase 1 of the following frame; the first frame's is stale.
    always_comb begin
        fir_ready = (state_reg == RUN);
        capture   = (state_reg == RUN) && (phase_reg == PHASE_W'(1)) && primed_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fir_sig    <= '0;
            primed_reg <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
        end else begin
            if (pop) fir_sig <= fifo_head;
            if ((state_reg == RUN) && (phase_reg == PHASE_W'(1))) primed_reg <= 1'b1;
            if (capture) begin
                out_valid <= 1'b1;
                out_data  <= fir_out;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef FIR_FEEDER_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if ((state_reg == WAIT) && fifo_empty && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Directed bench for fir_sample_feeder: frame-level reference model plus literal expectations.
module tb_fir_sample_feeder;

    localparam int WIDTH = 18;
    localparam int TAPS  = 128;
    localparam int DEPTH = 4;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             in_valid  = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data   = '0;
    logic [WIDTH-1:0] fir_sig;
    logic             fir_ready;
    logic [WIDTH-1:0] fir_out;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] out_data;
`ifdef FIR_FEEDER_STALL_CNT_EN
    logic [15:0]      stall_cnt;
`endif

    always #5 clk = ~clk;

    fir_sample_feeder #(
        .WIDTH      (WIDTH),
        .TAPS       (TAPS),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .fir_sig   (fir_sig),
        .fir_ready (fir_ready),
        .fir_out   (fir_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef FIR_FEEDER_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Reference model: sample queue, countdown of filter cycles left in the frame, frame index.
    int q[$];
    int m_sig;
    int m_od;
    bit m_ov;
    int frame_left;
    int frame_idx;
    int m_stall;

    int fir_val = 0;
    bit vary    = 1'b0;
    bit check7  = 1'b0;
    int cyc     = 0;
    int ready_cyc, rises, valid_cyc;
    bit prev_ready;

    assign fir_out = fir_val[WIDTH-1:0];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_sig = 0; m_od = 0; m_ov = 1'b0;
        frame_left = 0; frame_idx = 0; m_stall = 0;
    endtask

    // Advances the model across one rising edge using the inputs held during that cycle.
    task automatic model_step();
        int  pre_size = q.size();
        bit  run      = (frame_left > 0);
        int  pos      = TAPS - frame_left;
        bit  start    = (pre_size > 0) && (!m_ov || out_ready);
        bit  cap      = run && (pos == 1) && (frame_idx >= 2);
        if (!run && pre_size == 0 && m_stall < 65535) m_stall++;
        if (m_ov && out_ready && !cap) $display("out  sample %0d", m_od);
        if (cap) begin
            m_ov = 1'b1;
            m_od = int'($signed(fir_out));
        end else if (m_ov && out_ready) begin
            m_ov = 1'b0;
        end
        if ((!run || frame_left == 1) && start) begin
            m_sig = q.pop_front();
            frame_left = TAPS;
            frame_idx++;
        end else if (run) begin
            frame_left--;
        end
        if (in_valid && pre_size < DEPTH) begin
            q.push_back(int'($signed(in_data)));
            $display("in   sample %0d", int'($signed(in_data)));
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        model_step();
        chk("in_ready",  int'(in_ready),  int'(q.size() < DEPTH));
        chk("fir_ready", int'(fir_ready), int'(frame_left > 0));
        chk("fir_sig",   int'($signed(fir_sig)), m_sig);
        chk("out_valid", int'(out_valid), int'(m_ov));
        chk("out_data",  int'($signed(out_data)), m_od);
`ifdef FIR_FEEDER_STALL_CNT_EN
        chk("stall_cnt", int'(stall_cnt), m_stall);
`endif
        if (fir_ready) ready_cyc++;
        if (fir_ready && !prev_ready) rises++;
        prev_ready = fir_ready;
        if (out_valid) begin
            valid_cyc++;
            if (check7) chk("out_data_lit7", int'($signed(out_data)), 7);
        end
        if (vary) fir_val = ((cyc * 37) % 100000) - 50000;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_in_ready",  int'(in_ready),  1);
        chk("rst_fir_ready", int'(fir_ready), 0);
        chk("rst_fir_sig",   int'(fir_sig),   0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data",  int'(out_data),  0);
        prev_ready = 1'b0; ready_cyc = 0; rises = 0; valid_cyc = 0;
    endtask

    task automatic push(input int v);
        in_valid = 1'b1;
        in_data  = WIDTH'(v);
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        int waited;

        // Single sample: one 128-cycle frame, no output because the filter is unprimed.
        do_reset();
        vary = 1'b1;
        push(100);
        chk("t2_ready_c1", int'(fir_ready), 0);
        step();
        chk("t2_ready_c2", int'(fir_ready), 1);
        chk("t2_sig_c2",   int'($signed(fir_sig)), 100);
        repeat (200) step();
        chk("t2_ready_cycles", ready_cyc, 128);
        chk("t2_valid_cycles", valid_cyc, 0);

        // Three back-to-back frames with the filter output held at 7.
        do_reset();
        vary = 1'b0; fir_val = 7; check7 = 1'b1;
        push(10);
        push(-20);
        push(30);
        repeat (500) step();
        chk("t3_ready_cycles", ready_cyc, 384);
        chk("t3_ready_rises",  rises, 1);
        chk("t3_valid_cycles", valid_cyc, 2);
        chk("t3_last_sig",     int'($signed(fir_sig)), 30);
        check7 = 1'b0;

        // Downstream stall holds the result and blocks the next frame; buffer fills to four.
        do_reset();
        vary = 1'b1;
        push(10);
        push(-20);
        waited = 0;
        while (!out_valid && waited < 400) begin
            step();
            waited++;
        end
        chk("t4_capture_seen", int'(out_valid), 1);
        out_ready = 1'b0;
        repeat (200) step();
        chk("t4_valid_held", int'(out_valid), 1);
        chk("t4_waiting",    int'(fir_ready), 0);
        for (int k = 0; k < 5; k++) begin
            chk("t5_in_ready", int'(in_ready), int'(k < 4));
            in_valid = 1'b1;
            in_data  = WIDTH'(k + 1);
            step();
        end
        chk("t4_still_wait", int'(fir_ready), 0);
        chk("t5_full",       int'(in_ready), 0);
        in_data   = WIDTH'(99);
        out_ready = 1'b1;
        ready_cyc = 0;
        step();
        in_valid = 1'b0;
        chk("t4_run_after_release", int'(fir_ready), 1);
        chk("t4_sig_after_release", int'($signed(fir_sig)), 1);
        chk("t4_valid_cleared",     int'(out_valid), 0);
        chk("t5_slot_freed",        int'(in_ready), 1);
        repeat (700) step();
        chk("t5_drain_cycles", ready_cyc, 512);
        chk("t5_final_sig",    int'($signed(fir_sig)), 4);

        // Asynchronous reset in the middle of a frame.
        do_reset();
        vary = 1'b1;
        push(55);
        waited = 0;
        while (!fir_ready && waited < 10) begin
            step();
            waited++;
        end
        chk("t6_frame_started", int'(fir_ready), 1);
        repeat (50) step();
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_fir_ready", int'(fir_ready), 0);
        chk("t6_async_in_ready",  int'(in_ready),  1);
        chk("t6_async_fir_sig",   int'(fir_sig),   0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        prev_ready = 1'b0;
        repeat (20) step();
`ifdef FIR_FEEDER_STALL_CNT_EN
        chk("t6_stall_cnt_lit", int'(stall_cnt), 20);
`endif
        valid_cyc = 0;
        push(66);
        repeat (200) step();
        chk("t6_unprimed_valid", valid_cyc, 0);
        chk("t6_sig_after",      int'($signed(fir_sig)), 66);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
